// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size codes, FSM states,
// and the natural-alignment check used at request accept.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } lsu_state_t;

    // Only the low three address bits decide natural alignment.
    function automatic logic alignedFor(
        input logic [1:0] size,
        input logic [2:0] addr
    );
        logic ok;
        ok = 1'b1;
        case (size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = (addr[0] == 1'b0);
            SZ_W:    ok = (addr[1:0] == 2'b00);
            default: ok = (addr == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte lane logic: load extract + sign/zero extend, and
// sub-doubleword store merge into a captured line.
// Ports: line, off, size, uns, wdata in; load_data, merged out.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [63:0] line,
    input  logic [2:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [63:0] wdata,
    output logic [63:0] load_data,
    output logic [63:0] merged
);

    logic [63:0] shifted;
    logic [63:0] wdata_sh;
    logic [7:0]  base_mask;
    logic [7:0]  mask;
    logic        sx;

    assign shifted  = line >> {off, 3'b000};
    assign wdata_sh = wdata << {off, 3'b000};
    assign mask     = base_mask << off;

    always_comb begin
        load_data = shifted;
        sx        = 1'b0;
        unique case (size)
            SZ_B: begin
                sx        = ~uns & shifted[7];
                load_data = {{56{sx}}, shifted[7:0]};
            end
            SZ_H: begin
                sx        = ~uns & shifted[15];
                load_data = {{48{sx}}, shifted[15:0]};
            end
            SZ_W: begin
                sx        = ~uns & shifted[31];
                load_data = {{32{sx}}, shifted[31:0]};
            end
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        base_mask = 8'hFF;
        unique case (size)
            SZ_B:    base_mask = 8'h01;
            SZ_H:    base_mask = 8'h03;
            SZ_W:    base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
    end

    always_comb begin
        merged = line;
        for (int i = 0; i < 8; i++) begin
            if (mask[i])
                merged[8*i +: 8] = wdata_sh[8*i +: 8];
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit in front of dataMemory: doubleword accesses,
// load extract/extend, read-modify-write for narrow stores, error detect.
// Ports: req* handshake from EX, resp* handshake back, memAdd/writeData/
// memRead/memWrite/readData to dataMemory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqIsStore,
    input  logic [1:0]  reqSize,
    input  logic        reqUnsigned,
    input  logic [63:0] reqAddr,
    input  logic [63:0] reqWData,
    output logic        respValid,
    input  logic        respReady,
    output logic [63:0] respData,
    output logic        respMisalign,
    output logic        respFault,
    output logic [63:0] memAdd,
    output logic [63:0] writeData,
    output logic        memRead,
    output logic        memWrite,
    input  logic [63:0] readData
);

    lsu_state_t  state_q;
    lsu_state_t  state_d;

    logic [63:0] addr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        store_q;
    logic [63:0] wdata_q;
    logic [63:0] line_q;

    logic [63:0] rdata_q;
    logic        rmis_q;
    logic        rfault_q;

    logic        accept;
    logic        req_mis;
    logic        req_fault;
    logic [63:0] line_in;
    logic [63:0] load_data;
    logic [63:0] merged;

    assign accept    = reqValid && (state_q == ST_IDLE);
    assign req_mis   = !alignedFor(reqSize, reqAddr[2:0]);
    // Misalign wins: a misaligned out-of-range address reports only misalign.
    assign req_fault = !req_mis && (reqAddr >= 64'(MEM_BYTES));

    // During READ the line is not yet captured, so extract from the live bus.
    assign line_in = (state_q == ST_READ) ? readData : line_q;

    lsu_align u_align (
        .line      (line_in),
        .off       (addr_q[2:0]),
        .size      (size_q),
        .uns       (uns_q),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (reqValid) begin
                    if (req_mis || req_fault)
                        state_d = ST_RESP;
                    else if (!reqIsStore)
                        state_d = ST_READ;
                    else if (reqSize == SZ_D)
                        state_d = ST_WRITE;
                    else
                        state_d = ST_READ;
                end
            end
            ST_READ:  state_d = store_q ? ST_WRITE : ST_RESP;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = respReady ? ST_IDLE : ST_RESP;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            size_q   <= SZ_B;
            uns_q    <= 1'b0;
            store_q  <= 1'b0;
            wdata_q  <= '0;
            line_q   <= '0;
            rdata_q  <= '0;
            rmis_q   <= 1'b0;
            rfault_q <= 1'b0;
        end else begin
            if (accept) begin
                addr_q   <= reqAddr;
                size_q   <= reqSize;
                uns_q    <= reqUnsigned;
                store_q  <= reqIsStore;
                wdata_q  <= reqWData;
                rdata_q  <= '0;
                rmis_q   <= req_mis;
                rfault_q <= req_fault;
            end
            if (state_q == ST_READ) begin
                line_q <= readData;
                if (!store_q)
                    rdata_q <= load_data;
            end
        end
    end

    assign reqReady     = (state_q == ST_IDLE);
    assign memRead      = (state_q == ST_READ);
    assign memWrite     = (state_q == ST_WRITE);
    assign respValid    = (state_q == ST_RESP);
    assign respData     = rdata_q;
    assign respMisalign = rmis_q;
    assign respFault    = rfault_q;

    assign memAdd    = (memRead || memWrite) ? {addr_q[63:3], 3'b000} : '0;
    assign writeData = memWrite ? merged : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte[i]=i memory model and
// a queue scoreboard of expected responses.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reqValid;
    logic        reqReady;
    logic        reqIsStore;
    logic [1:0]  reqSize;
    logic        reqUnsigned;
    logic [63:0] reqAddr;
    logic [63:0] reqWData;
    logic        respValid;
    logic        respReady;
    logic [63:0] respData;
    logic        respMisalign;
    logic        respFault;
    logic [63:0] memAdd;
    logic [63:0] writeData;
    logic        memRead;
    logic        memWrite;
    logic [63:0] readData;

    typedef struct {
        logic [63:0] data;
        logic        mis;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic [7:0] mem [64];

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reqValid     (reqValid),
        .reqReady     (reqReady),
        .reqIsStore   (reqIsStore),
        .reqSize      (reqSize),
        .reqUnsigned  (reqUnsigned),
        .reqAddr      (reqAddr),
        .reqWData     (reqWData),
        .respValid    (respValid),
        .respReady    (respReady),
        .respData     (respData),
        .respMisalign (respMisalign),
        .respFault    (respFault),
        .memAdd       (memAdd),
        .writeData    (writeData),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .readData     (readData)
    );

    always_comb begin
        readData = '0;
        if (memAdd < 64'd64) begin
            for (int i = 0; i < 8; i++)
                readData[8*i +: 8] = mem[int'(memAdd[5:0]) + i];
        end
    end

    always @(posedge clk) begin
        if (memWrite && memAdd < 64'd64) begin
            for (int i = 0; i < 8; i++)
                mem[int'(memAdd[5:0]) + i] <= writeData[8*i +: 8];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(
        input string       nm,
        input logic        st,
        input logic [1:0]  sz,
        input logic        un,
        input logic [63:0] a,
        input logic [63:0] wd,
        input logic [63:0] ed,
        input logic        em,
        input logic        ef,
        input int          elat,
        input int          erd,
        input int          ewr,
        input int          hold
    );
        exp_t e;
        int   lat;
        int   nrd;
        int   nwr;
        int   w;
        e.data  = ed;
        e.mis   = em;
        e.fault = ef;
        sb.push_back(e);
        @(negedge clk);
        reqValid    = 1'b1;
        reqIsStore  = st;
        reqSize     = sz;
        reqUnsigned = un;
        reqAddr     = a;
        reqWData    = wd;
        w = 0;
        while (!reqReady && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({nm, ".ready"}, 64'(reqReady), 64'd1);
        @(posedge clk);
        #1 reqValid = 1'b0;
        lat = 0;
        nrd = 0;
        nwr = 0;
        do begin
            @(negedge clk);
            lat++;
            nrd += int'(memRead);
            nwr += int'(memWrite);
        end while (!respValid && lat < 20);
        chk({nm, ".valid"}, 64'(respValid), 64'd1);
        chk({nm, ".lat"}, 64'(lat), 64'(elat));
        chk({nm, ".reads"}, 64'(nrd), 64'(erd));
        chk({nm, ".writes"}, 64'(nwr), 64'(ewr));
        chk({nm, ".sb"}, 64'(sb.size()), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({nm, ".data"}, respData, e.data);
            chk({nm, ".mis"}, 64'(respMisalign), 64'(e.mis));
            chk({nm, ".fault"}, 64'(respFault), 64'(e.fault));
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk({nm, ".hvalid"}, 64'(respValid), 64'd1);
                chk({nm, ".hdata"}, respData, e.data);
                chk({nm, ".hmis"}, 64'(respMisalign), 64'(e.mis));
                chk({nm, ".hfault"}, 64'(respFault), 64'(e.fault));
                chk({nm, ".hready"}, 64'(reqReady), 64'd0);
                chk({nm, ".hmem"}, 64'({memRead, memWrite}), 64'd0);
            end
        end
        respReady = 1'b1;
        @(posedge clk);
        #1 respReady = 1'b0;
        chk({nm, ".idle"}, 64'({reqReady, respValid}), 64'b10);
    endtask

    initial begin
        for (int i = 0; i < 64; i++)
            mem[i] = 8'(i);
        rst_n       = 1'b0;
        reqValid    = 1'b0;
        reqIsStore  = 1'b0;
        reqSize     = 2'd0;
        reqUnsigned = 1'b0;
        reqAddr     = '0;
        reqWData    = '0;
        respReady   = 1'b0;
        #12;
        chk("rst.valid", 64'(respValid), 64'd0);
        chk("rst.mem", 64'({memRead, memWrite}), 64'd0);
        chk("rst.data", respData, 64'd0);
        chk("rst.flags", 64'({respMisalign, respFault}), 64'd0);
        chk("rst.addr", memAdd, 64'd0);
        chk("rst.wdata", writeData, 64'd0);
        chk("rst.ready", 64'(reqReady), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        do_req("ld08", 0, 2'd3, 0, 64'h08, 0,
               64'h0F0E0D0C0B0A0908, 0, 0, 2, 1, 0, 0);
        do_req("lh0a", 0, 2'd1, 0, 64'h0A, 0,
               64'h0B0A, 0, 0, 2, 1, 0, 0);
        do_req("lbu05", 0, 2'd0, 1, 64'h05, 0,
               64'h05, 0, 0, 2, 1, 0, 0);
        do_req("lw06", 0, 2'd2, 0, 64'h06, 0,
               64'h0, 1, 0, 1, 0, 0, 0);
        do_req("ld06", 0, 2'd3, 0, 64'h06, 0,
               64'h0, 1, 0, 1, 0, 0, 0);
        do_req("sw14", 1, 2'd2, 0, 64'h14, 64'hDEADBEEF,
               64'h0, 0, 0, 3, 1, 1, 0);
        do_req("ld10", 0, 2'd3, 0, 64'h10, 0,
               64'hDEADBEEF13121110, 0, 0, 2, 1, 0, 0);
        do_req("lw14", 0, 2'd2, 0, 64'h14, 0,
               64'hFFFFFFFFDEADBEEF, 0, 0, 2, 1, 0, 0);
        do_req("lwu14", 0, 2'd2, 1, 64'h14, 0,
               64'h00000000DEADBEEF, 0, 0, 2, 1, 0, 0);
        do_req("sb20", 1, 2'd0, 0, 64'h20, 64'h80,
               64'h0, 0, 0, 3, 1, 1, 0);
        do_req("lb20", 0, 2'd0, 0, 64'h20, 0,
               64'hFFFFFFFFFFFFFF80, 0, 0, 2, 1, 0, 0);
        do_req("lbu20", 0, 2'd0, 1, 64'h20, 0,
               64'h0000000000000080, 0, 0, 2, 1, 0, 0);
        do_req("lh20", 0, 2'd1, 0, 64'h20, 0,
               64'h2180, 0, 0, 2, 1, 0, 0);
        do_req("sd18", 1, 2'd3, 0, 64'h18, 64'h1122334455667788,
               64'h0, 0, 0, 2, 0, 1, 0);
        do_req("ld18", 0, 2'd3, 0, 64'h18, 0,
               64'h1122334455667788, 0, 0, 2, 1, 0, 0);
        do_req("ld40", 0, 2'd3, 0, 64'h40, 0,
               64'h0, 0, 1, 1, 0, 0, 5);
        do_req("lh41", 0, 2'd1, 0, 64'h41, 0,
               64'h0, 1, 0, 1, 0, 0, 0);
        do_req("sb3f", 1, 2'd0, 0, 64'h3F, 64'hA5,
               64'h0, 0, 0, 3, 1, 1, 0);
        do_req("ld38", 0, 2'd3, 0, 64'h38, 0,
               64'hA53E3D3C3B3A3938, 0, 0, 2, 1, 0, 0);

        // Reset while the narrow store sits in WRITE: nothing may commit.
        @(negedge clk);
        reqValid    = 1'b1;
        reqIsStore  = 1'b1;
        reqSize     = 2'd1;
        reqUnsigned = 1'b0;
        reqAddr     = 64'h30;
        reqWData    = 64'h1234;
        @(posedge clk);
        #1 reqValid = 1'b0;
        @(negedge clk);
        chk("rst6.read", 64'(memRead), 64'd1);
        @(negedge clk);
        chk("rst6.write", 64'(memWrite), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst6.wdrop", 64'(memWrite), 64'd0);
        chk("rst6.addr", memAdd, 64'd0);
        chk("rst6.wdata", writeData, 64'd0);
        chk("rst6.valid", 64'(respValid), 64'd0);
        chk("rst6.ready", 64'(reqReady), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        do_req("ld30", 0, 2'd3, 0, 64'h30, 0,
               64'h3736353433323130, 0, 0, 2, 1, 0, 0);

        chk("sb.empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
